spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 205 ++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a bank of NUM_REGS registers of DATA_W bits.
// SPI pins are oversampled in the clk domain; a frame is rw, address, data, all MSB first.
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         err_addr,
    output logic                         err_abort
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_RW, S_ADDR, S_DATA, S_DONE} state_t;

    logic [SYNC_STAGES-1:0]       r_sclk_sync;
    logic [SYNC_STAGES-1:0]       r_copi_sync;
    logic [SYNC_STAGES-1:0]       r_ncs_sync;
    logic [SYNC_STAGES-1:0]       r_flush;
    logic                         r_sclk_d;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_armed;
    logic                         r_rw;
    logic [ADDR_W-1:0]            r_addr;
    logic                         r_addr_ok;
    logic [DATA_W-1:0]            r_data;
    logic [DATA_W-1:0]            r_shift;
    logic                         r_rd_loaded;
    logic [NUM_REGS*DATA_W-1:0]   r_regs;
    logic                         r_cipo;
    logic                         r_cipo_oe;
    logic                         r_wr_stb;
    logic [ADDR_W-1:0]            r_wr_addr;
    logic                         r_err_addr;
    logic                         r_err_abort;

    logic                         w_sclk;
    logic                         w_copi;
    logic                         w_ncs;
    logic                         w_rise;
    logic                         w_fall;
    logic [ADDR_W-1:0]            w_addr_nx;
    logic [DATA_W-1:0]            w_data_nx;
    logic [DATA_W-1:0]            w_shl;
    logic [DATA_W-1:0]            w_rd_val;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    // Input synchronisers; r_flush marks when the ncs chain holds a real pin sample again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_flush     <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs     = r_ncs_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    assign w_addr_nx = (r_addr << 1) | ADDR_W'(w_copi);
    assign w_data_nx = (r_data << 1) | DATA_W'(w_copi);
    assign w_shl     = r_shift << 1;

    // Out-of-range addresses read back as zero because no entry matches.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == ADDR_W'(i)) w_rd_val = r_regs[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_rd_loaded <= 1'b0;
            r_regs      <= RESET_VAL;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_err_addr  <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_wr_stb    <= 1'b0;
            r_err_addr  <= 1'b0;
            r_err_abort <= 1'b0;
            r_cipo_oe   <= ~w_ncs;
            // A frame may only start after ncs has been seen high since reset.
            if (r_flush[SYNC_STAGES-1] && w_ncs) r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cipo <= 1'b0;
                    if (r_armed && !w_ncs) begin
                        r_state <= S_RW;
                        r_cnt   <= '0;
                    end
                end
                S_RW: begin
                    if (w_ncs) begin
                        r_state     <= S_IDLE;
                        r_err_abort <= 1'b1;
                    end else if (w_rise) begin
                        r_rw    <= w_copi;
                        r_state <= S_ADDR;
                        r_cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_ncs) begin
                        r_state     <= S_IDLE;
                        r_err_abort <= 1'b1;
                    end else if (w_rise) begin
                        r_addr <= w_addr_nx;
                        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                            r_state     <= S_DATA;
                            r_cnt       <= '0;
                            r_rd_loaded <= 1'b0;
                            r_addr_ok   <= addr_in_range(w_addr_nx);
                            if (!r_rw && !addr_in_range(w_addr_nx)) r_err_addr <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_ncs) begin
                        r_state     <= S_IDLE;
                        r_err_abort <= 1'b1;
                        r_cipo      <= 1'b0;
                    end else if (w_rise) begin
                        r_data <= w_data_nx;
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= S_DONE;
                            r_cipo  <= 1'b0;
                            if (r_rw && r_addr_ok) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (r_addr == ADDR_W'(i)) r_regs[i*DATA_W +: DATA_W] <= w_data_nx;
                                end
                                r_wr_stb  <= 1'b1;
                                r_wr_addr <= r_addr;
                            end else if (r_rw) begin
                                r_err_addr <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_fall && !r_rw) begin
                        if (!r_rd_loaded) begin
                            r_shift     <= w_rd_val;
                            r_cipo      <= w_rd_val[DATA_W-1];
                            r_rd_loaded <= 1'b1;
                        end else begin
                            r_shift <= w_shl;
                            r_cipo  <= w_shl[DATA_W-1];
                        end
                    end
                end
                S_DONE: begin
                    r_cipo <= 1'b0;
                    if (w_ncs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign regs      = r_regs;
    assign cipo      = r_cipo;
    assign cipo_oe   = r_cipo_oe;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign err_addr  = r_err_addr;
    assign err_abort = r_err_abort;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: a default-parameter instance and a 16x16-bit instance share sclk/copi.
// Expected write addresses go into a scoreboard queue as frames are driven and are matched against observed strobes.
module tb_spi_reg_bank;

    localparam int HP = 6;
    localparam logic [255:0] RV1 = {8{32'h1234_C3A5}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0;
    logic         copi = 1'b0;
    logic         ncs0 = 1'b1;
    logic         ncs1 = 1'b1;

    logic         cipo0, cipo_oe0, wr_stb0, err_addr0, err_abort0;
    logic [39:0]  regs0;
    logic [6:0]   wr_addr0;
    logic         cipo1, cipo_oe1, wr_stb1, err_addr1, err_abort1;
    logic [255:0] regs1;
    logic [3:0]   wr_addr1;

    int checks = 0;
    int errors = 0;
    int cnt_wr0 = 0, cnt_ea0 = 0, cnt_ab0 = 0;
    int cnt_wr1 = 0, cnt_ea1 = 0, cnt_ab1 = 0;
    int exp_wr0_q[$], obs_wr0_q[$], exp_wr1_q[$], obs_wr1_q[$];
    logic [39:0]  model0;
    logic [255:0] model1;

    spi_reg_bank u_dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs0),
        .cipo(cipo0), .cipo_oe(cipo_oe0), .regs(regs0), .wr_stb(wr_stb0),
        .wr_addr(wr_addr0), .err_addr(err_addr0), .err_abort(err_abort0)
    );

    spi_reg_bank #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2), .RESET_VAL(RV1)) u_dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs1),
        .cipo(cipo1), .cipo_oe(cipo_oe1), .regs(regs1), .wr_stb(wr_stb1),
        .wr_addr(wr_addr1), .err_addr(err_addr1), .err_abort(err_abort1)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_stb0) begin cnt_wr0++; obs_wr0_q.push_back(int'(wr_addr0)); end
        if (err_addr0) cnt_ea0++;
        if (err_abort0) cnt_ab0++;
        if (wr_stb1) begin cnt_wr1++; obs_wr1_q.push_back(int'(wr_addr1)); end
        if (err_addr1) cnt_ea1++;
        if (err_abort1) cnt_ab1++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] fr0(input bit rw, input int a, input int d);
        logic [63:0] f;
        f = '0;
        f[15] = rw;
        f[14:8] = 7'(a);
        f[7:0] = 8'(d);
        return f;
    endfunction

    function automatic logic [63:0] fr1(input bit rw, input int a, input int d);
        logic [63:0] f;
        f = '0;
        f[20] = rw;
        f[19:16] = 4'(a);
        f[15:0] = 16'(d);
        return f;
    endfunction

    // Mode-0 controller: copi set while sclk is low, cipo captured just before each rising edge.
    task automatic xfer(input int sel, input logic [63:0] frame, input int flen, input int npulses,
                        input int dw, input bit cs_low, input bit cs_high, output logic [31:0] rd);
        rd = '0;
        if (cs_low) begin
            if (sel == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
            ticks(HP);
        end
        for (int b = 0; b < npulses; b++) begin
            copi = (b < flen) ? frame[flen-1-b] : 1'b1;
            ticks(HP);
            if (b >= flen - dw && b < flen) rd = {rd[30:0], (sel == 0) ? cipo0 : cipo1};
            sclk = 1'b1;
            ticks(HP);
            sclk = 1'b0;
        end
        copi = 1'b0;
        ticks(HP);
        if (cs_high) begin
            ncs0 = 1'b1;
            ncs1 = 1'b1;
            ticks(2 * HP);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(4);
        checks++; if (regs0 !== 40'h0) begin errors++; $display("FAIL reset_regs0: got %h want %h", regs0, 40'h0); end
        checks++; if (regs1 !== RV1) begin errors++; $display("FAIL reset_regs1: got %h want %h", regs1, RV1); end
        checks++; if (cipo0 !== 1'b0 || cipo_oe0 !== 1'b0) begin errors++; $display("FAIL reset_cipo: got %b%b want 00", cipo0, cipo_oe0); end
        checks++; if (wr_stb0 !== 1'b0 || wr_addr0 !== 7'd0) begin errors++; $display("FAIL reset_wr: got %b/%0d want 0/0", wr_stb0, wr_addr0); end
        checks++; if (err_addr0 !== 1'b0 || err_abort0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", err_addr0, err_abort0); end
        rst = 1'b0;
        ticks(4);
        model0 = '0;
        model1 = RV1;
        cnt_wr0 = 0; cnt_ea0 = 0; cnt_ab0 = 0; cnt_wr1 = 0; cnt_ea1 = 0; cnt_ab1 = 0;
        obs_wr0_q.delete(); obs_wr1_q.delete();
    endtask

    task automatic test_cipo_oe();
        int ab;
        ab = cnt_ab0;
        ncs0 = 1'b0;
        ticks(HP);
        checks++; if (cipo_oe0 !== 1'b1) begin errors++; $display("FAIL oe_low_ncs: got %b want 1", cipo_oe0); end
        checks++; if (cipo0 !== 1'b0) begin errors++; $display("FAIL cipo_idle: got %b want 0", cipo0); end
        ncs0 = 1'b1;
        ticks(HP);
        checks++; if (cipo_oe0 !== 1'b0) begin errors++; $display("FAIL oe_high_ncs: got %b want 0", cipo_oe0); end
        checks++; if (cnt_ab0 - ab != 1) begin errors++; $display("FAIL empty_frame_abort: got %0d want 1", cnt_ab0 - ab); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        int wr, ea;
        wr = cnt_wr0; ea = cnt_ea0;
        xfer(0, fr0(1, 9, 8'hFF), 16, 16, 8, 1, 1, rd);
        checks++; if (cnt_ea0 - ea != 1) begin errors++; $display("FAIL bad_wr_err: got %0d want 1", cnt_ea0 - ea); end
        checks++; if (cnt_wr0 != wr) begin errors++; $display("FAIL bad_wr_stb: got %0d want 0", cnt_wr0 - wr); end
        checks++; if (regs0 !== model0) begin errors++; $display("FAIL bad_wr_regs: got %h want %h", regs0, model0); end
        ea = cnt_ea0;
        xfer(0, fr0(0, 9, 0), 16, 16, 8, 1, 1, rd);
        checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL bad_rd_data: got %h want 00", rd[7:0]); end
        checks++; if (cnt_ea0 - ea != 1) begin errors++; $display("FAIL bad_rd_err: got %0d want 1", cnt_ea0 - ea); end
    endtask

    task automatic test_write();
        logic [31:0] rd;
        int wr, o, e;
        wr = cnt_wr0;
        exp_wr0_q.push_back(2);
        model0[2*8 +: 8] = 8'hA5;
        xfer(0, fr0(1, 2, 8'hA5), 16, 16, 8, 1, 1, rd);
        checks++; if (cnt_wr0 - wr != 1) begin errors++; $display("FAIL wr_stb_count: got %0d want 1", cnt_wr0 - wr); end
        checks++; if (obs_wr0_q.size() != exp_wr0_q.size()) begin errors++; $display("FAIL wr_sb_size: got %0d want %0d", obs_wr0_q.size(), exp_wr0_q.size()); end
        while (obs_wr0_q.size() > 0 && exp_wr0_q.size() > 0) begin
            o = obs_wr0_q.pop_front(); e = exp_wr0_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL wr_addr: got %0d want %0d", o, e); end
        end
        exp_wr0_q.delete(); obs_wr0_q.delete();
        checks++; if (regs0 !== model0) begin errors++; $display("FAIL wr_regs: got %h want %h", regs0, model0); end
        checks++; if (rd[7:0] !== 8'h00) begin errors++; $display("FAIL wr_cipo_quiet: got %h want 00", rd[7:0]); end
    endtask

    task automatic test_read();
        logic [31:0] rd;
        int wr, ea;
        model0[4*8 +: 8] = 8'h3C;
        xfer(0, fr0(1, 4, 8'h3C), 16, 16, 8, 1, 1, rd);
        wr = cnt_wr0; ea = cnt_ea0;
        obs_wr0_q.delete();
        xfer(0, fr0(0, 4, 0), 16, 16, 8, 1, 1, rd);
        checks++; if (rd[7:0] !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h want 3c", rd[7:0]); end
        checks++; if (cnt_wr0 != wr || cnt_ea0 != ea) begin errors++; $display("FAIL rd_side_pulses: got wr %0d err %0d want 0 0", cnt_wr0 - wr, cnt_ea0 - ea); end
        checks++; if (regs0 !== model0) begin errors++; $display("FAIL rd_regs: got %h want %h", regs0, model0); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int wr, ab, o, e;
        wr = cnt_wr0; ab = cnt_ab0;
        xfer(0, fr0(1, 1, 8'h81), 16, 12, 8, 1, 1, rd);
        checks++; if (cnt_ab0 - ab != 1) begin errors++; $display("FAIL abort_pulse: got %0d want 1", cnt_ab0 - ab); end
        checks++; if (cnt_wr0 != wr) begin errors++; $display("FAIL abort_wr: got %0d want 0", cnt_wr0 - wr); end
        checks++; if (regs0[15:8] !== model0[15:8]) begin errors++; $display("FAIL abort_regs: got %h want %h", regs0[15:8], model0[15:8]); end
        exp_wr0_q.push_back(1);
        model0[1*8 +: 8] = 8'h81;
        xfer(0, fr0(1, 1, 8'h81), 16, 16, 8, 1, 1, rd);
        checks++; if (obs_wr0_q.size() != exp_wr0_q.size()) begin errors++; $display("FAIL abort_next_sb: got %0d want %0d", obs_wr0_q.size(), exp_wr0_q.size()); end
        while (obs_wr0_q.size() > 0 && exp_wr0_q.size() > 0) begin
            o = obs_wr0_q.pop_front(); e = exp_wr0_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL abort_next_addr: got %0d want %0d", o, e); end
        end
        exp_wr0_q.delete(); obs_wr0_q.delete();
        checks++; if (regs0 !== model0) begin errors++; $display("FAIL abort_next_regs: got %h want %h", regs0, model0); end
    endtask

    task automatic test_extra_pulses();
        logic [31:0] rd;
        int wr;
        wr = cnt_wr0;
        model0[7:0] = 8'h55;
        xfer(0, fr0(1, 0, 8'h55), 16, 20, 8, 1, 1, rd);
        obs_wr0_q.delete();
        checks++; if (cnt_wr0 - wr != 1) begin errors++; $display("FAIL extra_wr_count: got %0d want 1", cnt_wr0 - wr); end
        checks++; if (regs0 !== model0) begin errors++; $display("FAIL extra_regs: got %h want %h", regs0, model0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int wr, a, d, o, e;
        wr = cnt_wr0;
        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(0, 4));
            d = int'($urandom_range(0, 255));
            exp_wr0_q.push_back(a);
            model0[a*8 +: 8] = 8'(d);
            xfer(0, fr0(1, a, d), 16, 16, 8, 1, 1, rd);
        end
        checks++; if (cnt_wr0 - wr != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", cnt_wr0 - wr); end
        while (obs_wr0_q.size() > 0 && exp_wr0_q.size() > 0) begin
            o = obs_wr0_q.pop_front(); e = exp_wr0_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL b2b_addr: got %0d want %0d", o, e); end
        end
        exp_wr0_q.delete(); obs_wr0_q.delete();
        for (int r = 0; r < 5; r++) begin
            xfer(0, fr0(0, r, 0), 16, 16, 8, 1, 1, rd);
            checks++; if (rd[7:0] !== model0[r*8 +: 8]) begin errors++; $display("FAIL b2b_read%0d: got %h want %h", r, rd[7:0], model0[r*8 +: 8]); end
        end
    endtask

    task automatic test_wide();
        logic [31:0] rd;
        int wr, ab0, ab1, o, e;
        wr = cnt_wr1;
        exp_wr1_q.push_back(15);
        model1[15*16 +: 16] = 16'hBEEF;
        xfer(1, fr1(1, 15, 16'hBEEF), 21, 21, 16, 1, 1, rd);
        checks++; if (cnt_wr1 - wr != 1) begin errors++; $display("FAIL wide_wr_count: got %0d want 1", cnt_wr1 - wr); end
        while (obs_wr1_q.size() > 0 && exp_wr1_q.size() > 0) begin
            o = obs_wr1_q.pop_front(); e = exp_wr1_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL wide_wr_addr: got %0d want %0d", o, e); end
        end
        exp_wr1_q.delete(); obs_wr1_q.delete();
        checks++; if (regs1 !== model1) begin errors++; $display("FAIL wide_regs: got %h want %h", regs1, model1); end
        xfer(1, fr1(0, 15, 0), 21, 21, 16, 1, 1, rd);
        checks++; if (rd[15:0] !== 16'hBEEF) begin errors++; $display("FAIL wide_read: got %h want beef", rd[15:0]); end

        ab0 = cnt_ab0; ab1 = cnt_ab1;
        xfer(1, fr1(1, 3, 16'h1111), 21, 8, 16, 1, 0, rd);
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        ticks(2);
        model0 = '0;
        model1 = RV1;
        checks++; if (regs1 !== RV1) begin errors++; $display("FAIL midrst_regs1: got %h want %h", regs1, RV1); end
        checks++; if (regs0 !== 40'h0) begin errors++; $display("FAIL midrst_regs0: got %h want 0", regs0); end
        checks++; if (cnt_ab1 != ab1 || cnt_ab0 != ab0) begin errors++; $display("FAIL midrst_abort: got %0d %0d want 0 0", cnt_ab1 - ab1, cnt_ab0 - ab0); end

        wr = cnt_wr1;
        xfer(1, fr1(1, 3, 16'h2222), 21, 21, 16, 0, 1, rd);
        checks++; if (cnt_wr1 != wr) begin errors++; $display("FAIL midrst_held_ncs_wr: got %0d want 0", cnt_wr1 - wr); end
        checks++; if (regs1 !== model1) begin errors++; $display("FAIL midrst_held_ncs_regs: got %h want %h", regs1, model1); end
        obs_wr1_q.delete();

        exp_wr1_q.push_back(3);
        model1[3*16 +: 16] = 16'h3333;
        xfer(1, fr1(1, 3, 16'h3333), 21, 21, 16, 1, 1, rd);
        checks++; if (obs_wr1_q.size() != exp_wr1_q.size()) begin errors++; $display("FAIL post_rst_sb: got %0d want %0d", obs_wr1_q.size(), exp_wr1_q.size()); end
        while (obs_wr1_q.size() > 0 && exp_wr1_q.size() > 0) begin
            o = obs_wr1_q.pop_front(); e = exp_wr1_q.pop_front();
            checks++; if (o != e) begin errors++; $display("FAIL post_rst_addr: got %0d want %0d", o, e); end
        end
        checks++; if (regs1 !== model1) begin errors++; $display("FAIL post_rst_regs: got %h want %h", regs1, model1); end
    endtask

    initial begin
        test_reset();
        test_cipo_oe();
        test_bad_addr();
        test_write();
        test_read();
        test_abort();
        test_extra_pulses();
        test_back_to_back();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
